// File: rtl/cpu_multisim_pkg.sv
// rtl/cpu_multisim_pkg.sv - shared types and header field layout for the multisim rx framer
package cpu_multisim_pkg;

  localparam logic [7:0] MULTISIM_MAGIC = 8'hA5;

  localparam int HDR_MAGIC_LSB = 56;
  localparam int HDR_OP_LSB    = 40;
  localparam int HDR_LEN_LSB   = 32;
  localparam int HDR_TAG_LSB   = 0;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_MAGIC = 2'd1,
    ERR_LEN   = 2'd2,
    ERR_TAG   = 2'd3
  } rx_err_e;

  typedef struct packed {
    logic [63:0] data;
    logic        sof;
    logic        eof;
  } rx_beat_t;

  function automatic logic [7:0] hdr_magic(input logic [63:0] w);
    return w[HDR_MAGIC_LSB +: 8];
  endfunction

  function automatic logic [15:0] hdr_opcode(input logic [63:0] w);
    return w[HDR_OP_LSB +: 16];
  endfunction

  function automatic logic [7:0] hdr_len(input logic [63:0] w);
    return w[HDR_LEN_LSB +: 8];
  endfunction

  function automatic logic [31:0] hdr_tag(input logic [63:0] w);
    return w[HDR_TAG_LSB +: 32];
  endfunction

endpackage

// File: rtl/cpu_multisim_skid_buf.sv
// rtl/cpu_multisim_skid_buf.sv - 2-entry skid buffer with registered ready and valid
module cpu_multisim_skid_buf #(
  parameter type T = logic [65:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_vld,
  output logic in_rdy,
  input  T     in_data,
  output logic out_vld,
  input  logic out_rdy,
  output T     out_data
);

  T           buf0_q, buf0_d;
  T           buf1_q, buf1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       vld_q, vld_d;
  logic       rdy_q, rdy_d;
  logic       push, pop;

  // buf0 is always the head; buf1 only holds the second entry when occupancy is 2
  always_comb begin
    push   = in_vld && rdy_q;
    pop    = vld_q && out_rdy;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;

    if (pop && (cnt_q == 2'd2)) begin
      buf0_d = buf1_q;
    end else if (push && ((cnt_q == 2'd0) || pop)) begin
      buf0_d = in_data;
    end
    if (push && !pop && (cnt_q == 2'd1)) begin
      buf1_d = in_data;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    vld_d = (cnt_d != 2'd0);
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0_q <= '0;
      buf1_q <= '0;
      cnt_q  <= 2'd0;
      vld_q  <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      rdy_q  <= rdy_d;
    end
  end

  assign in_rdy   = rdy_q;
  assign out_vld  = vld_q;
  assign out_data = buf0_q;

endmodule

// File: rtl/cpu_multisim_rx_framer.sv
// rtl/cpu_multisim_rx_framer.sv - parses the multisim word stream into framed beats for this CPU
module cpu_multisim_rx_framer
  import cpu_multisim_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int ERR_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      cpu_index,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [63:0]      in_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [63:0]      out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic [ERR_W-1:0] err_cnt,
  output logic [31:0]      frame_cnt
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  rx_state_e        state_q, state_d;
  logic [7:0]       remain_q, remain_d;
  logic             err_pulse_q, err_pulse_d;
  rx_err_e          err_code_q, err_code_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]      frame_cnt_q, frame_cnt_d;

  logic     accept;
  logic     push_vld;
  rx_beat_t push_beat;
  rx_beat_t out_beat;
  logic [7:0] len;

  assign accept = in_vld && in_rdy;
  assign len    = hdr_len(in_data);

  always_comb begin
    state_d        = state_q;
    remain_d       = remain_q;
    err_code_d     = ERR_NONE;
    err_pulse_d    = 1'b0;
    err_cnt_d      = err_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    push_vld       = 1'b0;
    push_beat.data = in_data;
    push_beat.sof  = 1'b0;
    push_beat.eof  = 1'b0;

    if (accept) begin
      case (state_q)
        HDR: begin
          // Bad magic stays in HDR so the parser resyncs one word at a time
          if (hdr_magic(in_data) != MULTISIM_MAGIC) begin
            err_code_d = ERR_MAGIC;
          end else if (len > MAX_LEN_B) begin
            err_code_d = ERR_LEN;
          end else if (hdr_tag(in_data) != cpu_index) begin
            err_code_d = ERR_TAG;
            if (len != 8'd0) begin
              state_d  = DROP;
              remain_d = len;
            end
          end else begin
            push_vld      = 1'b1;
            push_beat.sof = 1'b1;
            push_beat.eof = (len == 8'd0);
            if (len != 8'd0) begin
              state_d  = PASS;
              remain_d = len;
            end
          end
        end
        PASS: begin
          push_vld      = 1'b1;
          push_beat.eof = (remain_q == 8'd1);
          remain_d      = remain_q - 8'd1;
          if (remain_q == 8'd1) state_d = HDR;
        end
        DROP: begin
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) state_d = HDR;
        end
        default: begin
          state_d  = HDR;
          remain_d = 8'd0;
        end
      endcase
    end

    if (err_code_d != ERR_NONE) begin
      err_pulse_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
    end

    if (out_vld && out_rdy && out_eof) frame_cnt_d = frame_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HDR;
      remain_q    <= 8'd0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_cnt_q   <= '0;
      frame_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Dropped words also pass through the in_rdy gate, keeping in_rdy purely registered
  cpu_multisim_skid_buf #(
    .T(rx_beat_t)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (push_vld),
    .in_rdy  (in_rdy),
    .in_data (push_beat),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_data(out_beat)
  );

  assign out_data  = out_beat.data;
  assign out_sof   = out_beat.sof;
  assign out_eof   = out_beat.eof;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign err_cnt   = err_cnt_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_cpu_multisim_rx_framer.sv
// tb/tb_cpu_multisim_rx_framer.sv - scoreboard bench for the multisim rx framer
module tb_cpu_multisim_rx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cpu_index = 32'd3;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [63:0] in_data = 64'd0;
  logic        out_vld;
  logic        out_rdy = 1'b1;
  logic [63:0] out_data;
  logic        out_sof;
  logic        out_eof;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic [15:0] err_cnt;
  logic [31:0] frame_cnt;

  int checks = 0;
  int failures = 0;

  logic [65:0] exp_beats[$];
  logic [1:0]  exp_errs[$];
  logic [65:0] mon_beat;
  logic [1:0]  mon_err;

  cpu_multisim_rx_framer #(
    .MAX_LEN(16),
    .ERR_W  (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_index(cpu_index),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_sof  (out_sof),
    .out_eof  (out_eof),
    .err_pulse(err_pulse),
    .err_code (err_code),
    .err_cnt  (err_cnt),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [63:0] hdr(input logic [7:0] m, input logic [15:0] op,
                                      input logic [7:0] len, input logic [31:0] tag);
    return {m, op, len, tag};
  endfunction

  // Called just after a rising edge; returns just after the edge that accepts the word.
  task automatic send_word(input logic [63:0] d, input bit fwd, input bit sof,
                           input bit eof, input logic [1:0] err);
    int n;
    n = 0;
    in_data = d;
    in_vld  = 1'b1;
    @(negedge clk);
    while (!in_rdy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_rdy) begin
      fail_now("send_timeout");
    end else begin
      if (fwd) exp_beats.push_back({d, sof, eof});
      if (err != 2'd0) exp_errs.push_back(err);
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_beats.size() != 0 && n < 200) begin
      n++;
      @(posedge clk);
    end
    if (exp_beats.size() != 0) fail_now("drain_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_vld && out_rdy) begin
        if (exp_beats.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          mon_beat = exp_beats.pop_front();
          check("beat_data", out_data, mon_beat[65:2]);
          check("beat_sof", 64'(out_sof), 64'(mon_beat[1]));
          check("beat_eof", 64'(out_eof), 64'(mon_beat[0]));
        end
      end
      if (err_pulse) begin
        if (exp_errs.size() == 0) begin
          fail_now("unexpected_err");
        end else begin
          mon_err = exp_errs.pop_front();
          check("err_code", 64'(err_code), 64'(mon_err));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_in_rdy", 64'(in_rdy), 64'd1);
    check("rst_out_data", out_data, 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: good frame, len 2
    send_word(hdr(8'hA5, 16'h0000, 8'd2, 32'd3), 1, 1, 0, 2'd0);
    send_word(64'h11, 1, 0, 0, 2'd0);
    send_word(64'h22, 1, 0, 1, 2'd0);
    drain();
    check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t1_err_cnt", 64'(err_cnt), 64'd0);

    // 2: bad magic, then a len-0 header
    send_word(hdr(8'h5A, 16'h0000, 8'd0, 32'd3), 0, 0, 0, 2'd1);
    send_word(hdr(8'hA5, 16'h0000, 8'd0, 32'd3), 1, 1, 1, 2'd0);
    drain();
    check("t2_err_cnt", 64'(err_cnt), 64'd1);
    check("t2_frame_cnt", 64'(frame_cnt), 64'd2);

    // 3: misaddressed frame is swallowed, next frame passes
    send_word(hdr(8'hA5, 16'h1234, 8'd3, 32'd7), 0, 0, 0, 2'd3);
    send_word(64'hAAAA, 0, 0, 0, 2'd0);
    send_word(64'hBBBB, 0, 0, 0, 2'd0);
    send_word(hdr(8'hA5, 16'h0000, 8'd0, 32'd3), 0, 0, 0, 2'd0);
    send_word(hdr(8'hA5, 16'hBEEF, 8'd1, 32'd3), 1, 1, 0, 2'd0);
    send_word(64'h33, 1, 0, 1, 2'd0);
    drain();
    check("t3_err_cnt", 64'(err_cnt), 64'd2);
    check("t3_frame_cnt", 64'(frame_cnt), 64'd3);

    // 4: len 17 over MAX_LEN, FSM must still be in HDR
    send_word(hdr(8'hA5, 16'h0000, 8'd17, 32'd3), 0, 0, 0, 2'd2);
    send_word(hdr(8'hA5, 16'h0001, 8'd0, 32'd3), 1, 1, 1, 2'd0);
    drain();
    check("t4_err_cnt", 64'(err_cnt), 64'd3);
    check("t4_frame_cnt", 64'(frame_cnt), 64'd4);

    // 5: downstream stall across a 4-word frame
    out_rdy = 1'b0;
    send_word(hdr(8'hA5, 16'h0055, 8'd3, 32'd3), 1, 1, 0, 2'd0);
    send_word(64'h44, 1, 0, 0, 2'd0);
    fork
      begin
        send_word(64'h55, 1, 0, 0, 2'd0);
        send_word(64'h66, 1, 0, 1, 2'd0);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          check("t5_stall_in_rdy", 64'(in_rdy), 64'd0);
          check("t5_stall_vld", 64'(out_vld), 64'd1);
          check("t5_stall_data", out_data, hdr(8'hA5, 16'h0055, 8'd3, 32'd3));
          check("t5_stall_sof", 64'(out_sof), 64'd1);
        end
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
      end
    join
    drain();
    check("t5_frame_cnt", 64'(frame_cnt), 64'd5);

    // 6: reset mid-frame; buffered beats are discarded, so none are expected
    out_rdy = 1'b0;
    send_word(hdr(8'hA5, 16'h0000, 8'd4, 32'd3), 0, 0, 0, 2'd0);
    send_word(64'h77, 0, 0, 0, 2'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_out_vld", 64'(out_vld), 64'd0);
    check("t6_in_rdy", 64'(in_rdy), 64'd1);
    check("t6_out_sof", 64'(out_sof), 64'd0);
    check("t6_out_eof", 64'(out_eof), 64'd0);
    check("t6_out_data", out_data, 64'd0);
    check("t6_err_pulse", 64'(err_pulse), 64'd0);
    check("t6_err_cnt", 64'(err_cnt), 64'd0);
    check("t6_frame_cnt", 64'(frame_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    send_word(hdr(8'hA5, 16'h00C3, 8'd1, 32'd3), 1, 1, 0, 2'd0);
    send_word(64'h88, 1, 0, 1, 2'd0);
    drain();
    check("t6_frame_cnt_after", 64'(frame_cnt), 64'd1);
    check("t6_err_cnt_after", 64'(err_cnt), 64'd0);

    check("beats_left", 64'(exp_beats.size()), 64'd0);
    check("errs_left", 64'(exp_errs.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_multisim_rx_framer.md
# cpu_multisim_rx_framer

Downstream consumer of the per-CPU multisim server stream. Accepts raw 64-bit words over a valid/ready handshake and parses them into framed transactions: one header word followed by `len` payload words. Valid frames addressed to this CPU are forwarded with SOF/EOF markers through a 2-entry skid buffer. Malformed or misaddressed words are discarded and counted.

## Interface
- `MAX_LEN`, default 16: largest legal payload length in words, range 1..255.
- `ERR_W`, default 16: width of the saturating error counter.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cpu_index`  in  32  index of this CPU, static after reset; compared against the header tag.
- `in_vld`  in  1  input word valid; driven from the server's `data_vld`.
- `in_rdy`  out  1  input ready; drives the server's `data_rdy`; registered.
- `in_data`  in  64  input word.
- `out_vld`  out  1  output beat valid.
- `out_rdy`  in  1  downstream ready.
- `out_data`  out  64  header or payload word.
- `out_sof`  out  1  beat is a header.
- `out_eof`  out  1  beat is the last beat of its frame.
- `err_pulse`  out  1  one-cycle pulse on any parse error.
- `err_code`  out  2  cause of the error: 1 = bad magic, 2 = bad length, 3 = tag mismatch; 0 when idle.
- `err_cnt`  out  ERR_W  saturating count of errors.
- `frame_cnt`  out  32  wrapping count of frames forwarded, incremented at the EOF beat's handshake.

## Operation
- **Handshakes**
  - An input word is accepted when `in_vld && in_rdy`.
  - An output beat transfers when `out_vld && out_rdy`.
- **Header fields**
  - [63:56] magic, must equal 8'hA5.
  - [55:40] opcode/reserved; not checked, passed through unchanged.
  - [39:32] `len`.
  - [31:0] tag.
- **FSM states:** HDR (reset), PASS, DROP. `remain` is an 8-bit count of payload words left.
- **HDR, on an accepted word:**
  - Magic ≠ A5: drop the word, error code 1, stay in HDR. This resyncs word by word.
  - Else if `len > MAX_LEN`: drop, error code 2, stay in HDR.
  - Else if tag ≠ `cpu_index`:
    - drop, error code 3;
    - if `len = 0`, stay in HDR; otherwise go to DROP with `remain = len`.
  - Else: push the header with `sof = 1`, `eof = (len == 0)`; if `len ≠ 0`, go to PASS with `remain = len`.
- **PASS, on an accepted word:** push with `sof = 0`, `eof = (remain == 1)`; decrement `remain`; at 1 → 0, go to HDR.
- **DROP, on an accepted word:** discard it (no error); decrement `remain`; at 1 → 0, go to HDR.
- **Input ready:** `in_rdy = !skid_full` in every state. Dropped words therefore also wait for buffer space; this keeps `in_rdy` free of combinational paths.
- **Error counter:** `err_cnt` holds at all-ones once saturated.
- **Frame counter:** `frame_cnt` wraps from 0xFFFFFFFF to 0.

## Timing
- **Reset values:**
  - `out_vld`, `out_sof`, `out_eof`, `err_pulse` = 0.
  - `out_data`, `err_code`, `err_cnt`, `frame_cnt` = 0.
  - `in_rdy` = 1 (buffer empty).
  - FSM in HDR, `remain` = 0.
- Reset asserted mid-frame discards the partial frame and all buffered beats; the first accepted word after reset is parsed as a header.
- **Latency:** an accepted word appears on `out_*` in the next cycle if the buffer was empty.
- **Errors:** `err_pulse`/`err_code` assert in the cycle after the offending accept and last one cycle. The counter updates in the same cycle.
- **Skid buffer:**
  - 2 entries, full throughput of 1 beat/cycle with `out_rdy` held high.
  - `in_rdy` deasserts the cycle after occupancy reaches 2.
  - A simultaneous push and pop at occupancy 2 is impossible (`in_rdy` = 0). At occupancy 1 it keeps occupancy at 1.
- **Output stability:** `out_*` hold stable while `out_vld && !out_rdy`.

## Structure
- **Package `cpu_multisim_pkg`:**
  - `MULTISIM_MAGIC` = 8'hA5;
  - header field bit positions;
  - `rx_state_e` {HDR, PASS, DROP};
  - `rx_err_e` {ERR_NONE, ERR_MAGIC, ERR_LEN, ERR_TAG};
  - packed struct `rx_beat_t` {data[63:0], sof, eof}.
- **Sub-module `cpu_multisim_skid_buf`:**
  - parameterised by payload type;
  - 2 entries;
  - registered ready and valid;
  - asynchronous active-low reset.
- The framer instantiates it once on the output side.

## Test plan
1. Header {A5, len 2, tag = `cpu_index` = 3}, then payloads 0x11 and 0x22, `out_rdy` = 1: three beats, with SOF on the header and EOF on 0x22. `frame_cnt` = 1, `err_cnt` = 0.
2. A word with magic 0x5A, then a valid `len = 0` header: first word dropped with `err_code` = 1 and `err_cnt` = 1. Then one beat with `sof = eof = 1`.
3. Header tag 7 ≠ `cpu_index` 3, `len = 3`, plus 3 payload words: no output beats, one error with code 3. The following valid header is forwarded.
4. Header with `len = 17`, `MAX_LEN = 16`: error code 2, word dropped, FSM remains in HDR.
5. `out_rdy` held low for 5 cycles during a 4-word frame: `in_rdy` drops after 2 accepts, `out_*` stay stable, and no beat is lost or duplicated on release.
6. `rst_n` pulsed low after the second word of a `len = 4` frame: outputs return to reset values; the next header is parsed correctly and `frame_cnt` counts only that frame.
